// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline constants and counter-width helper
package core_pkg;

    localparam int REGFILE_LEN = 6;
    localparam int MAX_LATENCY = 15;

    localparam int LAT_ALU     = 0;
    localparam int LAT_LOAD    = 1;
    localparam int LAT_FPU_ADD = 3;
    localparam int LAT_FPU_MUL = 4;
    localparam int LAT_FPU_DIV = 12;

    function automatic int cnt_width(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one register's pending-result countdown
module sb_counter
    import core_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A load overrides the decrement of the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW scoreboard and pipeline stall/bubble/flush control
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int REGFILE_LEN        = core_pkg::REGFILE_LEN,
    parameter int MAX_LATENCY        = core_pkg::MAX_LATENCY,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int STALL_CNT_WIDTH    = 32,
    localparam int CW                = core_pkg::cnt_width(MAX_LATENCY),
    localparam int NREG              = 2 ** REGFILE_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REGFILE_LEN-1:0]     id_rs1,
    input  logic [REGFILE_LEN-1:0]     id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [REGFILE_LEN-1:0]     id_rd,
    input  logic                       id_reg_write,
    input  logic [CW-1:0]              id_latency,
    input  logic                       redirect,
    input  logic                       ext_stall,
    output logic                       issue_fire,
    output logic                       pc_stall,
    output logic                       if_id_stall,
    output logic                       if_id_flush,
    output logic                       id_ex_bubble,
    output logic                       back_stall,
    output logic [NREG-1:0]            busy_vec,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    logic [CW-1:0]              cnt [NREG];
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            load_vec;
    logic [CW-1:0]              lat_c;
    logic                       raw;
    logic                       waw;
    logic                       hazard;
    logic                       fire;
    logic                       zero_rd;
    logic                       load_en;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;

    always_comb begin
        lat_c = id_latency;
        if (int'(id_latency) > MAX_LATENCY) begin
            lat_c = CW'(MAX_LATENCY);
        end
    end

    // Hazard compare against the ID-stage operands.
    always_comb begin
        raw     = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]));
        waw     = id_valid & id_reg_write & (cnt[id_rd] > lat_c);
        hazard  = raw | waw;
        fire    = id_valid & ~hazard & ~ext_stall;
        zero_rd = (ZERO_REG_HARDWIRED != 0) && (id_rd == '0);
        load_en = fire & id_reg_write & (lat_c != LAT_ALU[CW-1:0]) & ~zero_rd;
        load_vec = '0;
        if (load_en) begin
            load_vec = NREG'(1) << id_rd;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_cnt
            sb_counter #(
                .CW (CW)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .hold     (ext_stall),
                .load     (load_vec[g]),
                .load_val (lat_c),
                .cnt      (cnt[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !ext_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A redirect only flushes once its instruction actually leaves ID.
    assign issue_fire   = fire;
    assign pc_stall     = hazard | ext_stall;
    assign if_id_stall  = hazard | ext_stall;
    assign if_id_flush  = redirect & fire;
    assign id_ex_bubble = hazard & ~ext_stall;
    assign back_stall   = ext_stall;
    assign busy_vec     = busy;
    assign stall_cycles = stall_cnt_q;

endmodule
